// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port ownership and the
// per-port request bundle.
package dmem_arb_pkg;

  localparam int unsigned REQ_AW = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic              wren;
    logic [REQ_AW-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        bmask;
  } mem_req_t;

  function automatic mem_req_t make_req(input logic              wren,
                                        input logic [REQ_AW-1:0] addr,
                                        input logic [31:0]       wdata,
                                        input logic [3:0]        bmask);
    mem_req_t r;
    r.wren  = wren;
    r.addr  = addr;
    r.wdata = wdata;
    r.bmask = bmask;
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter_chk.sv
// Parameter legality and request-protocol checks for dmem_arbiter.
module dmem_arbiter_chk
  import dmem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32
) (
  input logic i_clk,
  input logic i_reset,
  input logic i_cpu_req,
  input logic i_cpu_gnt,
  input logic i_dbg_req,
  input logic i_dbg_gnt
);

  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT must be at least 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("dmem_arbiter: STARVE_MAX must be at least 1");
  end
  if (AW > REQ_AW) begin : g_bad_aw
    $error("dmem_arbiter: AW exceeds request bundle address width");
  end

  a_cpu_hold: assert property (@(posedge i_clk) disable iff (!i_reset)
    (i_cpu_req && !i_cpu_gnt) |=> i_cpu_req)
    else $error("cpu request withdrawn before grant");

  a_dbg_hold: assert property (@(posedge i_clk) disable iff (!i_reset)
    (i_dbg_req && !i_dbg_gnt) |=> i_dbg_req)
    else $error("dbg request withdrawn before grant");

endmodule

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating count of consecutive arbitrations the debug port has lost; the
// full flag forces the next debug request through.
module arb_starve_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_full
);

  localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign o_full = (cnt_q == W'(MAX));

  // Clear wins over increment; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = {W{1'b0}};
    end else if (i_inc && !o_full) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the pipeline MEM stage and the debug
// port: CPU priority with a starvation guard, read-latency sequencing, read routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cpu_req,
  input  logic          i_cpu_wren,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [31:0]   i_cpu_wdata,
  input  logic [3:0]    i_cpu_bmask,
  output logic          o_cpu_gnt,
  output logic          o_cpu_rvalid,
  output logic [31:0]   o_cpu_rdata,
  output logic          o_cpu_stall,
  input  logic          i_dbg_req,
  input  logic          i_dbg_wren,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [31:0]   i_dbg_wdata,
  input  logic [3:0]    i_dbg_bmask,
  output logic          o_dbg_gnt,
  output logic          o_dbg_rvalid,
  output logic [31:0]   o_dbg_rdata,
  output logic          o_mem_en,
  output logic          o_mem_wren,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_bmask,
  input  logic [31:0]   i_mem_rdata
);

  localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;

  logic     starve_full;
  logic     rsp_due;
  logic     issue_ok;
  logic     cpu_win;
  logic     dbg_win;
  logic     issue_read;
  mem_req_t cpu_fields;
  mem_req_t dbg_fields;
  mem_req_t win_fields;

  assign cpu_fields = make_req(i_cpu_wren, REQ_AW'(i_cpu_addr), i_cpu_wdata, i_cpu_bmask);
  assign dbg_fields = make_req(i_dbg_wren, REQ_AW'(i_dbg_addr), i_dbg_wdata, i_dbg_bmask);

  // Arbitration: a new access may issue in IDLE or in the cycle the pending read returns.
  always_comb begin
    rsp_due    = (state_q == ARB_WAIT) && (lat_cnt_q == {LW{1'b0}});
    issue_ok   = (state_q == ARB_IDLE) || rsp_due;
    dbg_win    = issue_ok && i_dbg_req && (starve_full || !i_cpu_req);
    cpu_win    = issue_ok && i_cpu_req && !dbg_win;
    win_fields = '0;
    if (dbg_win) begin
      win_fields = dbg_fields;
    end else if (cpu_win) begin
      win_fields = cpu_fields;
    end else begin
      win_fields = '0;
    end
    issue_read = (cpu_win || dbg_win) && !win_fields.wren;
  end

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (dbg_win),
    .i_inc   (cpu_win && i_dbg_req),
    .o_full  (starve_full)
  );

  assign o_cpu_gnt    = cpu_win;
  assign o_dbg_gnt    = dbg_win;
  assign o_cpu_stall  = i_cpu_req && !cpu_win;
  assign o_mem_en     = cpu_win || dbg_win;
  assign o_mem_wren   = win_fields.wren;
  assign o_mem_addr   = win_fields.addr[AW-1:0];
  assign o_mem_wdata  = win_fields.wdata;
  assign o_mem_bmask  = win_fields.bmask;
  assign o_cpu_rvalid = rsp_due && (owner_q == OWN_CPU);
  assign o_dbg_rvalid = rsp_due && (owner_q == OWN_DBG);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : 32'h0000_0000;
  assign o_dbg_rdata  = o_dbg_rvalid ? i_mem_rdata : 32'h0000_0000;

  // Next state: a read parks the FSM in WAIT for RD_LAT cycles; writes never leave IDLE.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (issue_read) begin
          state_d   = ARB_WAIT;
          owner_d   = dbg_win ? OWN_DBG : OWN_CPU;
          lat_cnt_d = LW'(RD_LAT - 1);
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if (!rsp_due) begin
          lat_cnt_d = lat_cnt_q - LW'(1'b1);
        end else if (issue_read) begin
          owner_d   = dbg_win ? OWN_DBG : OWN_CPU;
          lat_cnt_d = LW'(RD_LAT - 1);
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // FSM registers; an in-flight read is simply forgotten on reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_CPU;
      lat_cnt_q <= {LW{1'b0}};
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  dmem_arbiter_chk #(
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX),
    .AW         (AW)
  ) u_chk (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_cpu_req (i_cpu_req),
    .i_cpu_gnt (o_cpu_gnt),
    .i_dbg_req (i_dbg_req),
    .i_dbg_gnt (o_dbg_gnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences,
// then random traffic against a cycle-count/queue style reference model.
module tb_dmem_arbiter;

  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned AW         = 32;
  localparam int          NRAND      = 1500;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req, cpu_wren, dbg_req, dbg_wren;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic [3:0] cpu_bmask, dbg_bmask;
  logic cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic mem_en, mem_wren;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0] mem_bmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_wren(cpu_wren), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_bmask(cpu_bmask),
    .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .o_cpu_stall(cpu_stall),
    .i_dbg_req(dbg_req), .i_dbg_wren(dbg_wren), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .i_dbg_bmask(dbg_bmask),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
    .o_mem_en(mem_en), .o_mem_wren(mem_wren), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata)
  );

  // Memory macro model: 256 words, byte-masked writes, RD_LAT-deep read pipe.
  logic [31:0] mem_arr [0:255];
  logic [31:0] rd_pipe [0:RD_LAT-1];
  logic        mem_clear;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_en && mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_bmask[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (mem_en && !mem_wren) ? mem_arr[mem_addr[9:2]] : 32'h0;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic wren, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] bmask);
    cpu_req = req; cpu_wren = wren; cpu_addr = addr; cpu_wdata = wdata; cpu_bmask = bmask;
  endtask

  task automatic dbg_drive(input logic req, input logic wren, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] bmask);
    dbg_req = req; dbg_wren = wren; dbg_addr = addr; dbg_wdata = wdata; dbg_bmask = bmask;
  endtask

  function automatic logic any_out();
    return |{cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
             mem_en, mem_wren, mem_addr, mem_wdata, mem_bmask};
  endfunction

  typedef struct {
    logic        creq;
    logic        dreq;
    logic [31:0] caddr;
    logic [31:0] daddr;
    logic        cgnt;
    logic        dgnt;
    logic        stall;
    logic        en;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs [9];

  // Reference model state (random phase).
  logic [31:0] shadow [0:255];
  int          m_cyc, m_resp_cyc, m_starve;
  logic        m_resp_own;
  logic [31:0] m_resp_data;

  initial begin
    logic seen;
    int   ncpu;
    logic cg_seen, dg_seen;

    vecs[0] = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10};
    vecs[2] = '{1'b0, 1'b1, 32'h00, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20};
    vecs[3] = '{1'b1, 1'b1, 32'h30, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h30};
    vecs[4] = '{1'b0, 1'b1, 32'h00, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40};
    vecs[5] = '{1'b1, 1'b1, 32'h50, 32'h60, 1'b1, 1'b0, 1'b0, 1'b1, 32'h50};
    vecs[6] = '{1'b1, 1'b1, 32'h54, 32'h60, 1'b1, 1'b0, 1'b0, 1'b1, 32'h54};
    vecs[7] = '{1'b0, 1'b1, 32'h00, 32'h60, 1'b0, 1'b1, 1'b0, 1'b1, 32'h60};
    vecs[8] = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};

    // Reset and memory initialisation.
    rst_n = 1'b0;
    mem_clear = 1'b1;
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    dbg_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    next_cycle();
    mem_clear = 1'b0;
    @(negedge clk);
    chk("reset_outputs_zero", 64'(any_out()), 64'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_mem_en", 64'(mem_en), 64'h0);
    chk("release_outputs_zero", 64'(any_out()), 64'h0);
    next_cycle();

    // Arbitration table (all writes, FSM stays IDLE).
    for (int v = 0; v < 9; v++) begin
      cpu_drive(vecs[v].creq, 1'b1, vecs[v].caddr, vecs[v].caddr ^ 32'h5A5A_0000, 4'hF);
      dbg_drive(vecs[v].dreq, 1'b1, vecs[v].daddr, vecs[v].daddr ^ 32'h5A5A_0000, 4'hF);
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_gnt", v), 64'(cpu_gnt), 64'(vecs[v].cgnt));
      chk($sformatf("vec%0d_dbg_gnt", v), 64'(dbg_gnt), 64'(vecs[v].dgnt));
      chk($sformatf("vec%0d_stall", v), 64'(cpu_stall), 64'(vecs[v].stall));
      chk($sformatf("vec%0d_mem_en", v), 64'(mem_en), 64'(vecs[v].en));
      chk($sformatf("vec%0d_mem_addr", v), 64'(mem_addr), 64'(vecs[v].maddr));
      if (vecs[v].en)
        chk($sformatf("vec%0d_mem_wdata", v), 64'(mem_wdata), 64'(vecs[v].maddr ^ 32'h5A5A_0000));
      next_cycle();
    end
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    dbg_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Preload via CPU writes, including a partial byte mask.
    cpu_drive(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk); chk("wr0_gnt", 64'(cpu_gnt), 64'h1); next_cycle();
    cpu_drive(1'b1, 1'b1, 32'h104, 32'h1111_1111, 4'hF);
    @(negedge clk); chk("wr1_gnt", 64'(cpu_gnt), 64'h1); next_cycle();
    cpu_drive(1'b1, 1'b1, 32'h104, 32'hAABB_CCDD, 4'b0101);
    @(negedge clk);
    chk("wr2_gnt", 64'(cpu_gnt), 64'h1);
    chk("wr2_bmask", 64'(mem_bmask), 64'h5);
    next_cycle();

    // CPU read 0x100 then immediate second read of 0x104.
    cpu_drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd0_gnt", 64'(cpu_gnt), 64'h1);
    chk("rd0_wren", 64'(mem_wren), 64'h0);
    chk("rd0_addr", 64'(mem_addr), 64'h100);
    next_cycle();
    cpu_drive(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd1_wait_gnt", 64'(cpu_gnt), 64'h0);
    chk("rd1_wait_stall", 64'(cpu_stall), 64'h1);
    chk("rd1_wait_rvalid", 64'(cpu_rvalid), 64'h0);
    chk("rd1_wait_en", 64'(mem_en), 64'h0);
    next_cycle();
    @(negedge clk);
    chk("rd2_rvalid", 64'(cpu_rvalid), 64'h1);
    chk("rd2_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
    chk("rd2_dbg_rvalid", 64'(dbg_rvalid), 64'h0);
    chk("rd2_b2b_gnt", 64'(cpu_gnt), 64'h1);
    chk("rd2_b2b_addr", 64'(mem_addr), 64'h104);
    chk("rd2_stall", 64'(cpu_stall), 64'h0);
    next_cycle();
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd3_rvalid", 64'(cpu_rvalid), 64'h0);
    next_cycle();
    @(negedge clk);
    chk("rd4_rvalid", 64'(cpu_rvalid), 64'h1);
    chk("rd4_rdata", 64'(cpu_rdata), 64'h11BB_11DD);
    next_cycle();

    // Simultaneous writes: CPU first, DBG next cycle.
    cpu_drive(1'b1, 1'b1, 32'h88, 32'h1, 4'hF);
    dbg_drive(1'b1, 1'b1, 32'h8C, 32'h2, 4'hF);
    @(negedge clk);
    chk("both_cpu_gnt", 64'(cpu_gnt), 64'h1);
    chk("both_dbg_gnt", 64'(dbg_gnt), 64'h0);
    chk("both_stall", 64'(cpu_stall), 64'h0);
    next_cycle();
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("both_dbg_next_gnt", 64'(dbg_gnt), 64'h1);
    chk("both_dbg_next_addr", 64'(mem_addr), 64'h8C);
    next_cycle();

    // Starvation: CPU writes every cycle, DBG read held.
    cpu_drive(1'b1, 1'b1, 32'h80, 32'h3, 4'hF);
    dbg_drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_cpu_gnt", i), 64'(cpu_gnt), 64'h1);
      chk($sformatf("starve%0d_dbg_gnt", i), 64'(dbg_gnt), 64'h0);
      next_cycle();
    end
    @(negedge clk);
    chk("starve_force_dbg_gnt", 64'(dbg_gnt), 64'h1);
    chk("starve_force_cpu_gnt", 64'(cpu_gnt), 64'h0);
    chk("starve_force_stall", 64'(cpu_stall), 64'h1);
    chk("starve_force_addr", 64'(mem_addr), 64'h100);
    next_cycle();
    dbg_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("starve_wait_stall", 64'(cpu_stall), 64'h1);
    chk("starve_wait_gnt", 64'(cpu_gnt), 64'h0);
    next_cycle();
    dbg_drive(1'b1, 1'b1, 32'h84, 32'h4, 4'hF);
    @(negedge clk);
    chk("starve_dbg_rvalid", 64'(dbg_rvalid), 64'h1);
    chk("starve_dbg_rdata", 64'(dbg_rdata), 64'hDEAD_BEEF);
    chk("starve_cpu_rvalid", 64'(cpu_rvalid), 64'h0);
    seen = 1'b0;
    ncpu = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (dbg_gnt) begin
        seen = 1'b1;
      end else begin
        if (cpu_gnt) ncpu++;
        next_cycle();
        @(negedge clk);
      end
    end
    chk("starve_cleared_dbg_seen", 64'(seen), 64'h1);
    chk("starve_cleared_cpu_wins", 64'(ncpu), 64'h4);
    next_cycle();
    dbg_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("starve_cpu_after", 64'(cpu_gnt), 64'h1);
    next_cycle();
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset during WAIT drops the read.
    cpu_drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    chk("rstw_gnt", 64'(cpu_gnt), 64'h1);
    next_cycle();
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_outputs_zero", 64'(any_out()), 64'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstw_cpu_rvalid%0d", i), 64'(cpu_rvalid), 64'h0);
      chk($sformatf("rstw_dbg_rvalid%0d", i), 64'(dbg_rvalid), 64'h0);
      next_cycle();
    end

    // Random traffic against the reference model (addresses 0x200..0x3FC only).
    for (int i = 128; i < 256; i++) shadow[i] = 32'hA500_0000 | 32'(i);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m_cyc = 0; m_resp_cyc = -1; m_starve = 0; m_resp_own = 1'b0; m_resp_data = 32'h0;
    cg_seen = 1'b0; dg_seen = 1'b0;
    for (int n = 0; n < NRAND; n++) begin
      logic can, e_cg, e_dg, e_rv;
      logic [31:0] w_addr;
      if (cg_seen) cpu_req = 1'b0;
      if (dg_seen) dbg_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 3) != 0)
        cpu_drive(1'b1, 1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 127)) * 32'd4,
                  $urandom, 4'($urandom_range(0, 15)));
      if (!dbg_req && $urandom_range(0, 2) == 0)
        dbg_drive(1'b1, 1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 127)) * 32'd4,
                  $urandom, 4'($urandom_range(0, 15)));
      @(negedge clk);
      e_rv = (m_resp_cyc == m_cyc);
      can  = (m_resp_cyc < 0) || e_rv;
      e_cg = 1'b0;
      e_dg = 1'b0;
      if (can && dbg_req && (m_starve >= STARVE_MAX || !cpu_req)) e_dg = 1'b1;
      else if (can && cpu_req) e_cg = 1'b1;
      chk("rnd_cpu_gnt", 64'(cpu_gnt), 64'(e_cg));
      chk("rnd_dbg_gnt", 64'(dbg_gnt), 64'(e_dg));
      chk("rnd_stall", 64'(cpu_stall), 64'(cpu_req && !e_cg));
      chk("rnd_mem_en", 64'(mem_en), 64'(e_cg || e_dg));
      chk("rnd_cpu_rvalid", 64'(cpu_rvalid), 64'(e_rv && !m_resp_own));
      chk("rnd_dbg_rvalid", 64'(dbg_rvalid), 64'(e_rv && m_resp_own));
      if (e_rv && !m_resp_own) chk("rnd_cpu_rdata", 64'(cpu_rdata), 64'(m_resp_data));
      if (e_rv && m_resp_own)  chk("rnd_dbg_rdata", 64'(dbg_rdata), 64'(m_resp_data));
      if (e_cg || e_dg) begin
        w_addr = e_dg ? dbg_addr : cpu_addr;
        chk("rnd_mem_wren", 64'(mem_wren), 64'(e_dg ? dbg_wren : cpu_wren));
        chk("rnd_mem_addr", 64'(mem_addr), 64'(w_addr));
        chk("rnd_mem_wdata", 64'(mem_wdata), 64'(e_dg ? dbg_wdata : cpu_wdata));
        chk("rnd_mem_bmask", 64'(mem_bmask), 64'(e_dg ? dbg_bmask : cpu_bmask));
      end
      if (e_rv) m_resp_cyc = -1;
      if (e_cg && dbg_req && m_starve < STARVE_MAX) m_starve++;
      if (e_dg) m_starve = 0;
      if (e_cg || e_dg) begin
        if (!(e_dg ? dbg_wren : cpu_wren)) begin
          m_resp_cyc  = m_cyc + RD_LAT;
          m_resp_own  = e_dg;
          m_resp_data = shadow[w_addr[9:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if ((e_dg ? dbg_bmask[b] : cpu_bmask[b]))
              shadow[w_addr[9:2]][8*b +: 8] = e_dg ? dbg_wdata[8*b +: 8] : cpu_wdata[8*b +: 8];
        end
      end
      m_cyc++;
      cg_seen = e_cg;
      dg_seen = e_dg;
      if (n != NRAND - 1) next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
